// File: rtl/ysyx_25040109_ctrl_pkg.sv
// Shared types and constants for the core control sequencer.
package ysyx_25040109_ctrl_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_RST,
        ST_IF_REQ,
        ST_IF_WAIT,
        ST_EX,
        ST_LS_REQ,
        ST_LS_WAIT,
        ST_TRAP
    } state_e;

    // M-mode synchronous exception causes (low bits of mcause)
    localparam logic [3:0] CAUSE_IMISALIGN = 4'd0;
    localparam logic [3:0] CAUSE_IFAULT    = 4'd1;
    localparam logic [3:0] CAUSE_ILLEGAL   = 4'd2;
    localparam logic [3:0] CAUSE_BREAK     = 4'd3;
    localparam logic [3:0] CAUSE_LMISALIGN = 4'd4;
    localparam logic [3:0] CAUSE_LFAULT    = 4'd5;
    localparam logic [3:0] CAUSE_SMISALIGN = 4'd6;
    localparam logic [3:0] CAUSE_SFAULT    = 4'd7;
    localparam logic [3:0] CAUSE_ECALL_M   = 4'd11;

    // Memory access size codes
    localparam logic [1:0] MEM_B = 2'd0;
    localparam logic [1:0] MEM_H = 2'd1;
    localparam logic [1:0] MEM_W = 2'd2;

    // Instruction word presented to the IDU out of reset (addi x0, x0, 0)
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

    // True when an access of the given size is not naturally aligned
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        mis = 1'b0;
        case (size)
            MEM_H:   mis = addr_lo[0];
            MEM_W:   mis = (addr_lo != 2'b00);
            default: mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/ysyx_25040109_trap_sel.sv
// EX-stage exception priority encoder: decides whether the instruction in EX
// traps, and with which cause and trap value.
module ysyx_25040109_trap_sel
    import ysyx_25040109_ctrl_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            dec_illegal_i,
    input  logic            dec_ecall_i,
    input  logic            dec_ebreak_i,
    input  logic            dec_load_i,
    input  logic            dec_store_i,
    input  logic [1:0]      dec_mem_size_i,
    input  logic [XLEN-1:0] exu_next_pc_i,
    input  logic [XLEN-1:0] exu_mem_addr_i,
    output logic            trap_o,
    output logic [3:0]      cause_o,
    output logic [XLEN-1:0] tval_o
);

    logic mem_op;
    logic mem_mis;

    assign mem_op  = dec_load_i | dec_store_i;
    assign mem_mis = mem_op & is_misaligned(dec_mem_size_i, exu_mem_addr_i[1:0]);

    // Highest-priority exception wins; memory ops never take the jump-target check
    always_comb begin
        // NOTE: every output gets a default before the if-chain so no path leaves it unassigned (no latch).
        trap_o  = 1'b0;
        cause_o = CAUSE_IMISALIGN;
        tval_o  = '0;
        if (dec_illegal_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_ILLEGAL;
            tval_o  = XLEN'(inst_i);
        end else if (dec_ebreak_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_BREAK;
            tval_o  = pc_i;
        end else if (dec_ecall_i) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_ECALL_M;
        end else if (mem_mis) begin
            trap_o  = 1'b1;
            cause_o = dec_store_i ? CAUSE_SMISALIGN : CAUSE_LMISALIGN;
            tval_o  = exu_mem_addr_i;
        end else if (!mem_op && (exu_next_pc_i[1:0] != 2'b00)) begin
            trap_o  = 1'b1;
            cause_o = CAUSE_IMISALIGN;
            tval_o  = exu_next_pc_i;
        end
    end

endmodule

// File: rtl/ysyx_25040109_core_ctrl.sv
// Multi-cycle instruction sequencer: owns the PC, fetch and load/store
// handshakes, retirement counting, precise trap entry and mret.
module ysyx_25040109_core_ctrl
    import ysyx_25040109_ctrl_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(32'h8000_0000),
    parameter int              CNT_W    = 64
) (
    input  logic             clk,
    input  logic             rst,
    output logic             ifu_req_valid,
    input  logic             ifu_req_ready,
    output logic [XLEN-1:0]  ifu_addr,
    input  logic             ifu_rsp_valid,
    input  logic [31:0]      ifu_rsp_data,
    input  logic             ifu_rsp_err,
    output logic [31:0]      inst,
    input  logic             dec_illegal,
    input  logic             dec_ecall,
    input  logic             dec_ebreak,
    input  logic             dec_mret,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_rd_we,
    input  logic [XLEN-1:0]  exu_next_pc,
    input  logic [XLEN-1:0]  exu_mem_addr,
    input  logic [1:0]       dec_mem_size,
    output logic             lsu_req_valid,
    output logic             lsu_req_write,
    input  logic             lsu_req_ready,
    input  logic             lsu_rsp_valid,
    input  logic             lsu_rsp_err,
    input  logic [XLEN-1:0]  mtvec,
    input  logic [XLEN-1:0]  mepc,
    output logic             gpr_we,
    output logic             trap_we,
    output logic [XLEN-1:0]  trap_cause,
    output logic [XLEN-1:0]  trap_epc,
    output logic [XLEN-1:0]  trap_tval,
    output logic             commit,
    output logic [XLEN-1:0]  pc,
    output logic [CNT_W-1:0] minstret
);

    state_e            state_q;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   npc_q;
    logic [31:0]       inst_q;
    logic [3:0]        cause_q;
    logic [XLEN-1:0]   tval_q;
    logic [XLEN-1:0]   epc_q;
    logic [CNT_W-1:0]  minstret_q;

    logic              ex_trap;
    logic [3:0]        ex_cause;
    logic [XLEN-1:0]   ex_tval;
    logic              mem_op;
    logic              commit_w;

    assign mem_op = dec_load | dec_store;

    ysyx_25040109_trap_sel #(
        .XLEN(XLEN)
    ) u_trap_sel (
        .inst_i         (inst_q),
        .pc_i           (pc_q),
        .dec_illegal_i  (dec_illegal),
        .dec_ecall_i    (dec_ecall),
        .dec_ebreak_i   (dec_ebreak),
        .dec_load_i     (dec_load),
        .dec_store_i    (dec_store),
        .dec_mem_size_i (dec_mem_size),
        .exu_next_pc_i  (exu_next_pc),
        .exu_mem_addr_i (exu_mem_addr),
        .trap_o         (ex_trap),
        .cause_o        (ex_cause),
        .tval_o         (ex_tval)
    );

    // Retirement happens in the deciding cycle itself so the next fetch can start right after it
    assign commit_w = ((state_q == ST_EX) && !ex_trap && !mem_op)
                   || ((state_q == ST_LS_WAIT) && lsu_rsp_valid && !lsu_rsp_err);

    // Sequencer state, PC, latched instruction, trap record and retirement counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            npc_q      <= RESET_PC;
            inst_q     <= NOP_INST;
            cause_q    <= '0;
            tval_q     <= '0;
            epc_q      <= '0;
            minstret_q <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignments so every branch sees pre-edge values.
            case (state_q)
                ST_RST: begin
                    state_q <= ST_IF_REQ;
                end
                ST_IF_REQ: begin
                    if (ifu_req_ready) state_q <= ST_IF_WAIT;
                end
                ST_IF_WAIT: begin
                    if (ifu_rsp_valid) begin
                        inst_q <= ifu_rsp_data;
                        if (ifu_rsp_err) begin
                            cause_q <= CAUSE_IFAULT;
                            tval_q  <= pc_q;
                            epc_q   <= pc_q;
                            state_q <= ST_TRAP;
                        end else begin
                            state_q <= ST_EX;
                        end
                    end
                end
                ST_EX: begin
                    if (ex_trap) begin
                        cause_q <= ex_cause;
                        tval_q  <= ex_tval;
                        epc_q   <= pc_q;
                        state_q <= ST_TRAP;
                    end else if (mem_op) begin
                        npc_q   <= exu_next_pc;
                        state_q <= ST_LS_REQ;
                    end else if (dec_mret) begin
                        pc_q    <= mepc;
                        state_q <= ST_IF_REQ;
                    end else begin
                        pc_q    <= exu_next_pc;
                        state_q <= ST_IF_REQ;
                    end
                end
                ST_LS_REQ: begin
                    if (lsu_req_ready) state_q <= ST_LS_WAIT;
                end
                ST_LS_WAIT: begin
                    if (lsu_rsp_valid) begin
                        if (lsu_rsp_err) begin
                            cause_q <= dec_store ? CAUSE_SFAULT : CAUSE_LFAULT;
                            tval_q  <= exu_mem_addr;
                            epc_q   <= pc_q;
                            state_q <= ST_TRAP;
                        end else begin
                            pc_q    <= npc_q;
                            state_q <= ST_IF_REQ;
                        end
                    end
                end
                ST_TRAP: begin
                    // Trap record is only meaningful while trap_we is high; clear it on exit
                    pc_q    <= mtvec & ~XLEN'(32'h3);
                    cause_q <= '0;
                    tval_q  <= '0;
                    epc_q   <= '0;
                    state_q <= ST_IF_REQ;
                end
                default: begin
                    state_q <= ST_RST;
                end
            endcase

            if (commit_w) minstret_q <= minstret_q + CNT_W'(1);
        end
    end

    assign ifu_req_valid = (state_q == ST_IF_REQ);
    assign ifu_addr      = pc_q;
    assign inst          = inst_q;
    assign lsu_req_valid = (state_q == ST_LS_REQ);
    assign lsu_req_write = (state_q == ST_LS_REQ) & dec_store;
    assign commit        = commit_w;
    assign gpr_we        = commit_w & dec_rd_we;
    assign trap_we       = (state_q == ST_TRAP);
    assign trap_cause    = XLEN'(cause_q);
    assign trap_epc      = epc_q;
    assign trap_tval     = tval_q;
    assign pc            = pc_q;
    assign minstret      = minstret_q;

endmodule
